median_rank_filter: RTL

Parametrised rank-order filter for the image-processing datapath: accepts one window of WIN unsigned DATA_W-bit samples per handshake and returns the sample at a selected rank. The median is the default rank. The window is sorted in place by a sequential odd-even transposition network, one phase per cycle. Valid/ready handshakes on both sides let it sit between the window builder and the pixel writer.

---
 rtl/median_pkg.sv | 19 +
 rtl/median_rank_filter_cmp_swap.sv | 18 +
 rtl/median_rank_filter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/median_pkg.sv
// Shared types and constants for the median_rank_filter block.
// The optional rank-select feature is enabled by defining MEDIAN_RANK_SEL_EN.
package median_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MIN_WIN = 3;
  localparam int MAX_WIN = 25;

  // Position of the median in an ascending window of odd length win.
  function automatic int medpos(input int win);
    return (win - 1) / 2;
  endfunction

endpackage

// File: rtl/median_rank_filter_cmp_swap.sv
// Combinational compare-swap cell: lo/hi of two unsigned samples.
// Inputs are passed straight through unless a > b, so equal values never move.
module cmp_swap #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] hi
);

  logic w_swap;

  assign w_swap = (a > b);
  assign lo     = w_swap ? b : a;
  assign hi     = w_swap ? a : b;

endmodule

// File: rtl/median_rank_filter.sv
// Rank-order filter: accepts one window of WIN unsigned samples, sorts it
// with a sequential odd-even transposition network (one phase per clock)
// and returns the sample at the selected rank.
// Define MEDIAN_RANK_SEL_EN to add the rank_i port; otherwise the block is a
// fixed median filter.
module median_rank_filter
  import median_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int WIN    = 9,
  parameter int RANK_W = $clog2(WIN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIN*DATA_W-1:0] in_data,
`ifdef MEDIAN_RANK_SEL_EN
  input  logic [RANK_W-1:0]     rank_i,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  busy
);

  localparam int PH_W  = $clog2(WIN);
  localparam int NPAIR = WIN / 2;
  localparam int MED   = medpos(WIN);

  localparam logic [PH_W-1:0]   LAST_PH  = PH_W'(WIN - 1);
  localparam logic [RANK_W-1:0] MAX_RANK = RANK_W'(WIN - 1);
  localparam logic [RANK_W-1:0] MED_RANK = RANK_W'(MED);

  // Reject window lengths the network is not built for.
  if ((WIN % 2) == 0 || WIN < MIN_WIN || WIN > MAX_WIN) begin : g_bad_win
    $fatal(1, "median_rank_filter: WIN must be odd and within 3..25");
  end

  state_e            r_state;
  logic [PH_W-1:0]   r_phase;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [DATA_W-1:0] r_arr  [WIN];

  logic [DATA_W-1:0] w_even [WIN];
  logic [DATA_W-1:0] w_odd  [WIN];
  logic [DATA_W-1:0] w_next [WIN];
  logic [RANK_W-1:0] w_rank;
  logic              w_accept;

`ifdef MEDIAN_RANK_SEL_EN
  logic [RANK_W-1:0] r_rank;
  logic [RANK_W-1:0] w_rank_clamped;

  // Out-of-range requests saturate at the maximum.
  assign w_rank_clamped = (rank_i > MAX_RANK) ? MAX_RANK : rank_i;
  assign w_rank         = r_rank;
`else
  assign w_rank = MED_RANK;
`endif

  // Even phase: pairs (0,1),(2,3)...; the last lane has no partner.
  for (genvar i = 0; i < NPAIR; i++) begin : g_even
    cmp_swap #(.DATA_W(DATA_W)) u_cs (
      .a  (r_arr[2*i]),
      .b  (r_arr[2*i+1]),
      .lo (w_even[2*i]),
      .hi (w_even[2*i+1])
    );
  end
  assign w_even[WIN-1] = r_arr[WIN-1];

  // Odd phase: pairs (1,2),(3,4)...; lane 0 has no partner.
  for (genvar i = 0; i < NPAIR; i++) begin : g_odd
    cmp_swap #(.DATA_W(DATA_W)) u_cs (
      .a  (r_arr[2*i+1]),
      .b  (r_arr[2*i+2]),
      .lo (w_odd[2*i+1]),
      .hi (w_odd[2*i+2])
    );
  end
  assign w_odd[0] = r_arr[0];

  // Select the compare-swap set matching the current phase parity.
  always_comb begin
    for (int k = 0; k < WIN; k++) begin
      w_next[k] = r_phase[0] ? w_odd[k] : w_even[k];
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  // Control FSM, sample array, phase counter and registered result.
  // NOTE: every register here uses <= so all state updates see the values
  // from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_phase     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      // NOTE: the sample array is small register storage, not a RAM, so it
      // is cleared by reset like the rest of the state.
      for (int k = 0; k < WIN; k++) begin
        r_arr[k] <= '0;
      end
`ifdef MEDIAN_RANK_SEL_EN
      r_rank      <= MED_RANK;
`endif
    end else if (clr) begin
      // Abort wins over every transition; the array keeps its contents.
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            for (int k = 0; k < WIN; k++) begin
              r_arr[k] <= in_data[k*DATA_W +: DATA_W];
            end
`ifdef MEDIAN_RANK_SEL_EN
            r_rank  <= w_rank_clamped;
`endif
            r_phase <= '0;
            r_state <= SORT;
          end
        end
        SORT: begin
          r_arr <= w_next;
          if (r_phase == LAST_PH) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_out_data  <= w_next[w_rank];
          end else begin
            r_phase <= r_phase + PH_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
